// File: rtl/err_est_if.sv
// Bus between the error-estimator feeder, the detection-event source, the estimator and the host.
interface err_est_if #(
    parameter int unsigned NV_W = 21,
    parameter int unsigned NU_W = 25,
    parameter int unsigned NO_W = 21
);
    logic            i_evt_vld;
    logic [1:0]      i_evt_type;
    logic            i_evt_err;
    logic            i_blk_end;
    logic [31:0]     i_nleak;
    logic            o_start;
    logic [NV_W-1:0] o_nv;
    logic [NU_W-1:0] o_nu;
    logic [NO_W-1:0] o_no;
    logic [NV_W-1:0] o_mv;
    logic [NV_W-1:0] o_mo;
    logic [31:0]     o_nleak;
    logic [31:0]     i_err_value;
    logic            i_err_value_vld;
    logic            i_err_cal_busy;
    logic            i_cal_error;
    logic [31:0]     o_key_len;
    logic            o_key_len_vld;
    logic            o_key_err;
    logic            o_blk_overrun;
    logic            o_sat;
    logic            o_busy;

    modport master (
        input  i_evt_vld, i_evt_type, i_evt_err, i_blk_end, i_nleak,
        input  i_err_value, i_err_value_vld, i_err_cal_busy, i_cal_error,
        output o_start, o_nv, o_nu, o_no, o_mv, o_mo, o_nleak,
        output o_key_len, o_key_len_vld, o_key_err, o_blk_overrun, o_sat, o_busy
    );

    modport slave (
        output i_evt_vld, i_evt_type, i_evt_err, i_blk_end, i_nleak,
        output i_err_value, i_err_value_vld, i_err_cal_busy, i_cal_error,
        input  o_start, o_nv, o_nu, o_no, o_mv, o_mo, o_nleak,
        input  o_key_len, o_key_len_vld, o_key_err, o_blk_overrun, o_sat, o_busy
    );
endinterface

// File: rtl/err_est_feeder.sv
// Per-block detection counters feeding the QKD error/key-length estimator, with result capture.
// Optional macro FEEDER_CLAMP_EN: a negative estimator result is captured as key length 0.
module err_est_feeder #(
    parameter int unsigned NV_W    = 21,
    parameter int unsigned NU_W    = 25,
    parameter int unsigned NO_W    = 21,
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned TIMEOUT = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    err_est_if.master  bus
);
    typedef enum logic [1:0] {COLLECT, WAIT_IDLE, START, WAIT_RES} state_t;

    localparam logic [NV_W-1:0]  NV_MAX   = '1;
    localparam logic [NU_W-1:0]  NU_MAX   = '1;
    localparam logic [NO_W-1:0]  NO_MAX   = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [NV_W-1:0]  cnt_nv, cnt_mv, cnt_mo, nv_nxt, mv_nxt, mo_nxt;
    logic [NU_W-1:0]  cnt_nu, nu_nxt;
    logic [NO_W-1:0]  cnt_no, no_nxt;
    logic             blk_sat;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ev_v, ev_u, ev_o, er_v, er_o;
    logic             sat_now;
    logic             snap, take_res, take_tmo, overrun;
    logic [31:0]      res_value;

    // Saturating next values; the event of a closing cycle is folded into the snapshot
    always_comb begin
        ev_v    = bus.i_evt_vld && (bus.i_evt_type == 2'b00);
        ev_u    = bus.i_evt_vld && (bus.i_evt_type == 2'b01);
        ev_o    = bus.i_evt_vld && (bus.i_evt_type == 2'b10);
        er_v    = ev_v && bus.i_evt_err;
        er_o    = ev_o && bus.i_evt_err;
        sat_now = (ev_v && cnt_nv == NV_MAX) || (ev_u && cnt_nu == NU_MAX) ||
                  (ev_o && cnt_no == NO_MAX) || (er_v && cnt_mv == NV_MAX) ||
                  (er_o && cnt_mo == NV_MAX);
        nv_nxt  = (ev_v && cnt_nv != NV_MAX) ? cnt_nv + NV_W'(1) : cnt_nv;
        nu_nxt  = (ev_u && cnt_nu != NU_MAX) ? cnt_nu + NU_W'(1) : cnt_nu;
        no_nxt  = (ev_o && cnt_no != NO_MAX) ? cnt_no + NO_W'(1) : cnt_no;
        mv_nxt  = (er_v && cnt_mv != NV_MAX) ? cnt_mv + NV_W'(1) : cnt_mv;
        mo_nxt  = (er_o && cnt_mo != NV_MAX) ? cnt_mo + NV_W'(1) : cnt_mo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.i_blk_end) begin
            cnt_nv  <= '0;
            cnt_nu  <= '0;
            cnt_no  <= '0;
            cnt_mv  <= '0;
            cnt_mo  <= '0;
            blk_sat <= 1'b0;
        end else begin
            cnt_nv  <= nv_nxt;
            cnt_nu  <= nu_nxt;
            cnt_no  <= no_nxt;
            cnt_mv  <= mv_nxt;
            cnt_mo  <= mo_nxt;
            blk_sat <= blk_sat | sat_now;
        end
    end

`ifdef FEEDER_CLAMP_EN
    assign res_value = bus.i_err_value[31] ? 32'h0 : bus.i_err_value;
`else
    assign res_value = bus.i_err_value;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        take_res  = 1'b0;
        take_tmo  = 1'b0;
        overrun   = bus.i_blk_end && (state != COLLECT);
        case (state)
            COLLECT: begin
                if (bus.i_blk_end) begin
                    snap      = 1'b1;
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (!bus.i_err_cal_busy) state_nxt = START;
            START:     state_nxt = WAIT_RES;
            WAIT_RES: begin
                // A result arriving on the last window cycle still beats the timeout
                if (bus.i_err_value_vld) begin
                    take_res  = 1'b1;
                    state_nxt = COLLECT;
                end else if (tmo_cnt == TMO_LAST) begin
                    take_tmo  = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                 tmo_cnt <= '0;
        else if (state == START)    tmo_cnt <= '0;
        else if (state == WAIT_RES) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.o_start       <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_blk_overrun <= 1'b0;
            bus.o_key_len_vld <= 1'b0;
            bus.o_key_len     <= '0;
            bus.o_key_err     <= 1'b0;
            bus.o_nv          <= '0;
            bus.o_nu          <= '0;
            bus.o_no          <= '0;
            bus.o_mv          <= '0;
            bus.o_mo          <= '0;
            bus.o_nleak       <= '0;
            bus.o_sat         <= 1'b0;
        end else begin
            bus.o_start       <= (state_nxt == START);
            bus.o_busy        <= (state_nxt != COLLECT);
            bus.o_blk_overrun <= overrun;
            bus.o_key_len_vld <= take_res | take_tmo;
            if (snap) begin
                bus.o_nv    <= nv_nxt;
                bus.o_nu    <= nu_nxt;
                bus.o_no    <= no_nxt;
                bus.o_mv    <= mv_nxt;
                bus.o_mo    <= mo_nxt;
                bus.o_nleak <= bus.i_nleak;
                bus.o_sat   <= blk_sat | sat_now;
            end
            if (take_res) begin
                bus.o_key_len <= res_value;
                bus.o_key_err <= bus.i_cal_error;
            end else if (take_tmo) begin
                bus.o_key_len <= 32'h0;
                bus.o_key_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_err_est_feeder.sv
// Directed bench for err_est_feeder: block-level behavioural model compared every cycle, plus literal pins.
module tb_err_est_feeder;
    localparam int unsigned NV_W    = 8;
    localparam int unsigned NU_W    = 10;
    localparam int unsigned NO_W    = 8;
    localparam int unsigned TMO_W   = 8;
    localparam int unsigned TIMEOUT = 40;
    localparam int NV_MAX = (1 << NV_W) - 1;
    localparam int NU_MAX = (1 << NU_W) - 1;
    localparam int NO_MAX = (1 << NO_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    err_est_if #(.NV_W(NV_W), .NU_W(NU_W), .NO_W(NO_W)) bus ();

    err_est_feeder #(
        .NV_W(NV_W), .NU_W(NU_W), .NO_W(NO_W), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [31:0] captured(input logic [31:0] v);
`ifdef FEEDER_CLAMP_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Model: raw (unbounded) block counts, and where the current block is in its life:
    // 0 counting, 1 waiting for an idle estimator, 2 launch cycle, 3 waiting for the result.
    int m_cv, m_cu, m_co, m_ev, m_eo, m_phase, m_waited;
    int n_cv, n_cu, n_co, n_ev, n_eo, n_ph;
    logic take, tmo;
    logic armed = 1'b0;
    logic            e_start, e_kvld, e_kerr, e_ovr, e_sat, e_busy;
    logic [NV_W-1:0] e_nv, e_mv, e_mo;
    logic [NU_W-1:0] e_nu;
    logic [NO_W-1:0] e_no;
    logic [31:0]     e_nleak, e_klen;

    always_comb begin
        n_cv = m_cv + ((bus.i_evt_vld && bus.i_evt_type == 2'd0) ? 1 : 0);
        n_cu = m_cu + ((bus.i_evt_vld && bus.i_evt_type == 2'd1) ? 1 : 0);
        n_co = m_co + ((bus.i_evt_vld && bus.i_evt_type == 2'd2) ? 1 : 0);
        n_ev = m_ev + ((bus.i_evt_vld && bus.i_evt_type == 2'd0 && bus.i_evt_err) ? 1 : 0);
        n_eo = m_eo + ((bus.i_evt_vld && bus.i_evt_type == 2'd2 && bus.i_evt_err) ? 1 : 0);
        n_ph = m_phase;
        take = 1'b0;
        tmo  = 1'b0;
        case (m_phase)
            0: if (bus.i_blk_end) n_ph = 1;
            1: if (!bus.i_err_cal_busy) n_ph = 2;
            2: n_ph = 3;
            3: begin
                if (bus.i_err_value_vld) begin
                    take = 1'b1;
                    n_ph = 0;
                end else if (m_waited == int'(TIMEOUT) - 1) begin
                    tmo  = 1'b1;
                    n_ph = 0;
                end
            end
            default: n_ph = 0;
        endcase
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b1;
            m_cv <= 0; m_cu <= 0; m_co <= 0; m_ev <= 0; m_eo <= 0;
            m_phase <= 0; m_waited <= 0;
            e_start <= 1'b0; e_kvld <= 1'b0; e_kerr <= 1'b0; e_ovr <= 1'b0;
            e_sat <= 1'b0; e_busy <= 1'b0;
            e_nv <= '0; e_mv <= '0; e_mo <= '0; e_nu <= '0; e_no <= '0;
            e_nleak <= '0; e_klen <= '0;
        end else begin
            m_cv <= bus.i_blk_end ? 0 : n_cv;
            m_cu <= bus.i_blk_end ? 0 : n_cu;
            m_co <= bus.i_blk_end ? 0 : n_co;
            m_ev <= bus.i_blk_end ? 0 : n_ev;
            m_eo <= bus.i_blk_end ? 0 : n_eo;
            if (bus.i_blk_end && m_phase == 0) begin
                e_nv    <= NV_W'(clip(n_cv, NV_MAX));
                e_nu    <= NU_W'(clip(n_cu, NU_MAX));
                e_no    <= NO_W'(clip(n_co, NO_MAX));
                e_mv    <= NV_W'(clip(n_ev, NV_MAX));
                e_mo    <= NV_W'(clip(n_eo, NV_MAX));
                e_nleak <= bus.i_nleak;
                e_sat   <= (n_cv > NV_MAX) || (n_cu > NU_MAX) || (n_co > NO_MAX) ||
                           (n_ev > NV_MAX) || (n_eo > NV_MAX);
            end
            e_ovr   <= bus.i_blk_end && (m_phase != 0);
            e_start <= (n_ph == 2) && (m_phase == 1);
            e_kvld  <= take || tmo;
            if (take) begin
                e_klen <= captured(bus.i_err_value);
                e_kerr <= bus.i_cal_error;
            end else if (tmo) begin
                e_klen <= 32'h0;
                e_kerr <= 1'b1;
            end
            m_waited <= (m_phase == 2) ? 0 : m_waited + 1;
            m_phase  <= n_ph;
            e_busy   <= (n_ph != 0);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("o_start",       bus.o_start,       e_start);
            check("o_busy",        bus.o_busy,        e_busy);
            check("o_blk_overrun", bus.o_blk_overrun, e_ovr);
            check("o_key_len_vld", bus.o_key_len_vld, e_kvld);
            check("o_key_len",     bus.o_key_len,     e_klen);
            check("o_key_err",     bus.o_key_err,     e_kerr);
            check("o_nv",          bus.o_nv,          e_nv);
            check("o_nu",          bus.o_nu,          e_nu);
            check("o_no",          bus.o_no,          e_no);
            check("o_mv",          bus.o_mv,          e_mv);
            check("o_mo",          bus.o_mo,          e_mo);
            check("o_nleak",       bus.o_nleak,       e_nleak);
            check("o_sat",         bus.o_sat,         e_sat);
        end
    end

    task automatic idle();
        bus.i_evt_vld = 1'b0;
        bus.i_blk_end = 1'b0;
        bus.i_err_value_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic ev_n(input logic [1:0] t, input logic e, input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_evt_vld = 1'b1;
            bus.i_evt_type = t;
            bus.i_evt_err = e;
            bus.i_blk_end = 1'b0;
            bus.i_err_value_vld = 1'b0;
            @(negedge clk);
        end
        bus.i_evt_vld = 1'b0;
    endtask

    task automatic blk(input logic [31:0] nl, input logic with_ev, input logic [1:0] t);
        bus.i_blk_end = 1'b1;
        bus.i_nleak = nl;
        bus.i_evt_vld = with_ev;
        bus.i_evt_type = t;
        bus.i_evt_err = 1'b0;
        bus.i_err_value_vld = 1'b0;
        @(negedge clk);
        bus.i_blk_end = 1'b0;
        bus.i_evt_vld = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (bus.o_start !== 1'b1 && n < 200) begin
            idle();
            n++;
        end
        check("start_seen", bus.o_start, 1'b1);
    endtask

    // Called on the cycle o_start is seen: pass the launch cycle, then return a result.
    task automatic finish_block(input logic [31:0] val, input logic cerr);
        idle();
        bus.i_err_value = val;
        bus.i_cal_error = cerr;
        bus.i_err_value_vld = 1'b1;
        @(negedge clk);
        bus.i_err_value_vld = 1'b0;
        check("result_vld", bus.o_key_len_vld, 1'b1);
        check("result_err", bus.o_key_err, cerr);
        check("result_idle", bus.o_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        bus.i_evt_vld = 1'b0; bus.i_evt_type = 2'd0; bus.i_evt_err = 1'b0;
        bus.i_blk_end = 1'b0; bus.i_nleak = '0; bus.i_err_value = '0;
        bus.i_err_value_vld = 1'b0; bus.i_err_cal_busy = 1'b0; bus.i_cal_error = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.o_busy, 1'b0);
        check("reset_nv", bus.o_nv, 0);
        check("reset_key_len", bus.o_key_len, 0);
        rst_n = 1'b1;
        idle();

        // Block 1: last decoy arrives on the closing cycle and must be counted
        ev_n(2'd0, 1'b1, 2); ev_n(2'd0, 1'b0, 3); ev_n(2'd1, 1'b0, 100);
        ev_n(2'd3, 1'b1, 4);
        ev_n(2'd2, 1'b1, 3); ev_n(2'd2, 1'b0, 26);
        blk(32'd64, 1'b1, 2'd2);
        check("b1_nv", bus.o_nv, 5);   check("b1_mv", bus.o_mv, 2);
        check("b1_nu", bus.o_nu, 100); check("b1_no", bus.o_no, 30);
        check("b1_mo", bus.o_mo, 3);   check("b1_nleak", bus.o_nleak, 64);
        wait_start(n);
        check("b1_start_latency", n + 1, 2);
        finish_block(32'd1234, 1'b0);
        check("b1_key_len", bus.o_key_len, 32'd1234);

        // Block 2: estimator busy for 10 cycles after the block closes
        bus.i_err_cal_busy = 1'b1;
        ev_n(2'd1, 1'b0, 4);
        blk(32'd77, 1'b0, 2'd0);
        check("b2_nu", bus.o_nu, 4);
        repeat (10) idle();
        check("b2_no_start_while_busy", bus.o_start, 1'b0);
        bus.i_err_cal_busy = 1'b0;
        wait_start(n);
        check("b2_start_after_busy", n, 1);
        finish_block(32'd500, 1'b1);
        check("b2_key_len", bus.o_key_len, 32'd500);

        // Block 3: no result -> timeout
        ev_n(2'd0, 1'b0, 1);
        blk(32'd1, 1'b0, 2'd0);
        wait_start(n);
        n = 0;
        while (bus.o_key_len_vld !== 1'b1 && n < int'(TIMEOUT) + 20) begin
            idle();
            n++;
        end
        check("b3_timeout_cycles", n, TIMEOUT + 1);
        check("b3_key_len", bus.o_key_len, 0);
        check("b3_key_err", bus.o_key_err, 1'b1);
        check("b3_busy", bus.o_busy, 1'b0);

        // Block 4: result on the last cycle of the window wins over the timeout
        blk(32'd2, 1'b0, 2'd0);
        wait_start(n);
        repeat (TIMEOUT) idle();
        bus.i_err_value = 32'd777; bus.i_cal_error = 1'b0; bus.i_err_value_vld = 1'b1;
        @(negedge clk);
        bus.i_err_value_vld = 1'b0;
        check("b4_vld", bus.o_key_len_vld, 1'b1);
        check("b4_key_len", bus.o_key_len, 32'd777);
        check("b4_key_err", bus.o_key_err, 1'b0);

        // Block 5: a second close while waiting for the result is discarded
        ev_n(2'd0, 1'b0, 7);
        blk(32'd9, 1'b0, 2'd0);
        wait_start(n);
        idle();
        ev_n(2'd1, 1'b0, 3);
        blk(32'd99, 1'b1, 2'd2);
        check("b5_overrun", bus.o_blk_overrun, 1'b1);
        check("b5_nv_held", bus.o_nv, 7);
        check("b5_nu_held", bus.o_nu, 0);
        check("b5_nleak_held", bus.o_nleak, 9);
        check("b5_busy", bus.o_busy, 1'b1);
        ev_n(2'd2, 1'b0, 2);
        finish_block(32'd55, 1'b0);
        ev_n(2'd2, 1'b0, 2);
        blk(32'd5, 1'b0, 2'd0);
        check("b6_no", bus.o_no, 4);
        check("b6_nu", bus.o_nu, 0);
        check("b6_nleak", bus.o_nleak, 5);
        wait_start(n);
        finish_block(32'd66, 1'b0);

        // Saturation, then a clean block clears o_sat
        ev_n(2'd0, 1'b1, NV_MAX + 5);
        blk(32'd3, 1'b0, 2'd0);
        check("sat_nv", bus.o_nv, NV_MAX);
        check("sat_mv", bus.o_mv, NV_MAX);
        check("sat_flag", bus.o_sat, 1'b1);
        wait_start(n);
        finish_block(32'd10, 1'b0);
        ev_n(2'd1, 1'b0, 1);
        blk(32'd4, 1'b0, 2'd0);
        check("clean_sat", bus.o_sat, 1'b0);
        check("clean_nv", bus.o_nv, 0);
        wait_start(n);
        finish_block(32'd11, 1'b0);

        // Negative result
        ev_n(2'd1, 1'b0, 3);
        blk(32'd6, 1'b0, 2'd0);
        wait_start(n);
        finish_block(32'hFFFF_FF00, 1'b0);
`ifdef FEEDER_CLAMP_EN
        check("neg_key_len", bus.o_key_len, 32'h0);
`else
        check("neg_key_len", bus.o_key_len, 32'hFFFF_FF00);
`endif

        // Reset while waiting for the result
        ev_n(2'd2, 1'b1, 2);
        blk(32'd8, 1'b0, 2'd0);
        check("rst_pre_no", bus.o_no, 2);
        wait_start(n);
        idle(); idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_no", bus.o_no, 0);
        check("rst_mo", bus.o_mo, 0);
        check("rst_nleak", bus.o_nleak, 0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_key_len", bus.o_key_len, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < int'(TIMEOUT) + 5; i++) begin
            idle();
            if (bus.o_key_len_vld === 1'b1) seen++;
        end
        check("rst_no_result", seen, 0);
        ev_n(2'd0, 1'b0, 2);
        blk(32'd10, 1'b0, 2'd0);
        check("post_rst_nv", bus.o_nv, 2);
        wait_start(n);
        finish_block(32'd42, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/err_est_feeder.md
Name: err_est_feeder

Overview:
- Front-end initiator for the QKD error/key-length estimator.
- Accumulates per-pulse detection events into five counters for each sifting block: vacuum, signal and decoy detections, plus vacuum and decoy errors.
- At block end it snapshots the counters and nleak, issues a one-cycle start once the estimator is idle, then waits for the result, with a timeout.
- Captures the final key length and error flag for the post-processing host.

Parameters:
- NV_W, 21, width of vacuum count and of vacuum/decoy error counts.
- NU_W, 25, width of signal count.
- NO_W, 21, width of decoy count.
- TMO_W, 16, width of the result-timeout counter.
- TIMEOUT, 16'd4000, number of WAIT_RES cycles before abort.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- i_evt_vld  in  1  one detection event this cycle.
- i_evt_type  in  2  event type: 00 vacuum, 01 signal, 10 decoy, 11 ignored.
- i_evt_err  in  1  event is a bit error; counted only for vacuum and decoy.
- i_blk_end  in  1  one-cycle pulse closing the current block.
- i_nleak  in  32  leaked bits of the closing block; sampled on i_blk_end.
- o_start  out  1  one-cycle start to the estimator.
- o_nv  out  NV_W  vacuum detection count; held stable from snapshot until the next snapshot.
- o_nu  out  NU_W  signal detection count; same hold rule.
- o_no  out  NO_W  decoy detection count; same hold rule.
- o_mv  out  NV_W  vacuum error count; same hold rule.
- o_mo  out  NV_W  decoy error count; same hold rule.
- o_nleak  out  32  latched nleak.
- i_err_value  in  32  estimator result.
- i_err_value_vld  in  1  estimator result valid.
- i_err_cal_busy  in  1  estimator busy.
- i_cal_error  in  1  estimator error flag.
- o_key_len  out  32  captured key length.
- o_key_len_vld  out  1  one-cycle pulse when o_key_len is updated.
- o_key_err  out  1  estimator error or timeout for the captured result.
- o_blk_overrun  out  1  one-cycle pulse when a block is discarded.
- o_sat  out  1  sticky; some counter saturated in the last snapshotted block.
- o_busy  out  1  high whenever the state is not COLLECT.

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - All outputs and accumulators go to 0.
  - State goes to COLLECT.
- Accumulators run in every state.
  - On i_evt_vld, increment the selected count. For vacuum or decoy, also increment the error count when i_evt_err=1.
  - Each counter saturates at all-ones and does not wrap. Saturation sets an internal block-sat flag.
- On i_blk_end, the event of that same cycle belongs to the closing block. The accumulators then clear to 0 on that edge; if the same-cycle event is dropped, count it into the new block instead.
- Corrected rule, replacing the previous bullet: the event arriving on the i_blk_end cycle is included in the snapshot, and the accumulators restart at 0 on the next cycle.
- FSM states: COLLECT, WAIT_IDLE, START, WAIT_RES.
  - COLLECT, on i_blk_end: load o_nv/o_nu/o_no/o_mv/o_mo and o_nleak. Copy block-sat to o_sat. Go to WAIT_IDLE.
  - WAIT_IDLE: stay while i_err_cal_busy=1. Otherwise go to START.
  - START: o_start=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_RES.
  - WAIT_RES, on i_err_value_vld: o_key_len<=i_err_value, o_key_err<=i_cal_error, o_key_len_vld=1 next cycle. Go to COLLECT.
  - WAIT_RES timeout: the counter increments each cycle. On reaching TIMEOUT-1 without vld: o_key_len<=0, o_key_err<=1, o_key_len_vld pulse. Go to COLLECT.
  - WAIT_RES, vld and timeout in the same cycle: vld wins.
- i_blk_end while not in COLLECT: the closing block is discarded. o_blk_overrun pulses, accumulators clear, the o_n* snapshot is unchanged, and the state is unchanged.
- o_start is never reasserted before the previous result or timeout.
- Latency: i_blk_end to o_start is 2 cycles when the estimator is idle.
- Reset mid-operation: an immediate return to COLLECT with all outputs 0. No o_key_len_vld is generated for the aborted block.

Optional Feature:
- Macro: FEEDER_CLAMP_EN.
- Defined: when i_err_value[31]=1 (negative key length), the captured o_key_len is 32'h0. o_key_err is unaffected.
- Undefined: i_err_value is captured unmodified.

Test Plan:
- Events: 5 vacuum (2 err), 100 signal, 30 decoy (3 err), then i_blk_end with i_nleak=64 and busy=0.
  - Response: o_nv=5, o_mv=2, o_nu=100, o_no=30, o_mo=3, o_nleak=64. o_start arrives 2 cycles after blk_end.
  - Then i_err_value_vld with 32'd1234 gives o_key_len=1234, o_key_len_vld 1 cycle, o_key_err=0.
- i_err_cal_busy held high 10 cycles after blk_end -> o_start arrives on the cycle after busy falls, exactly once.
- No i_err_value_vld after start -> after TIMEOUT cycles: o_key_len=0, o_key_err=1, o_key_len_vld pulse, o_busy=0.
- Second i_blk_end during WAIT_RES -> o_blk_overrun pulse, snapshot unchanged. The next block starts counting from 0.
- 2^21 vacuum events -> o_nv=21'h1FFFFF, o_sat=1 after blk_end. The next clean block leaves o_sat=0.
- i_err_value=32'hFFFF_FF00 -> o_key_len=0 with FEEDER_CLAMP_EN, 32'hFFFF_FF00 without. rst_n=0 in WAIT_RES clears all outputs.
